// File: rtl/fpusb_pkg.sv
// Shared constants for the USB result path.
package fpusb_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/tx_fifo_ram.sv
// Byte storage for tx_byte_fifo: synchronous write port, asynchronous read port.
module tx_fifo_ram
  import fpusb_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk_pll,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_pll) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tx_byte_fifo.sv
// First-word-fall-through byte FIFO between the word unpacker and the USB transmit side.
// word_space tells the result source whether a whole 32-bit result still fits.
module tx_byte_fifo
  import fpusb_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk_pll,
  input  logic              reset_n,
  input  logic              FIFO_push_data,
  input  logic [BYTE_W-1:0] FIFO_input_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] out_data,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       count,
  output logic              word_space,
  output logic              overflow,
  input  logic              clear_overflow
);

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);
  localparam logic [AW:0] WordLimit = (AW+1)'(DEPTH - WORD_BYTES);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              push_ok, pop_ok, push_drop;
  logic [BYTE_W-1:0] ram_rdata;

  assign empty      = (count_q == '0);
  assign full       = (count_q == FullCount);
  assign word_space = (count_q <= WordLimit);
  assign count      = count_q;
  assign overflow   = overflow_q;

  // A pop frees the slot the push needs, so a full FIFO still accepts push+pop.
  assign pop_ok    = pop && !empty;
  assign push_ok   = FIFO_push_data && (!full || pop_ok);
  assign push_drop = FIFO_push_data && !push_ok;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (push_drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_pll) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  tx_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_pll (clk_pll),
    .we      (push_ok && reset_n),
    .waddr   (wr_ptr_q),
    .wdata   (FIFO_input_data),
    .raddr   (rd_ptr_q),
    .rdata   (ram_rdata)
  );

  assign out_data = empty ? '0 : ram_rdata;

endmodule

// File: tb/tb_tx_byte_fifo.sv
// Directed bench for tx_byte_fifo: a vector table plus hand-written corner sequences.
module tb_tx_byte_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk_pll = 1'b0;
  logic          reset_n;
  logic          FIFO_push_data;
  logic [7:0]    FIFO_input_data;
  logic          pop;
  logic [7:0]    out_data;
  logic          empty, full, word_space, overflow;
  logic [AW:0]   count;
  logic          clear_overflow;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_pll = ~clk_pll;

  tx_byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk_pll         (clk_pll),
    .reset_n         (reset_n),
    .FIFO_push_data  (FIFO_push_data),
    .FIFO_input_data (FIFO_input_data),
    .pop             (pop),
    .out_data        (out_data),
    .empty           (empty),
    .full            (full),
    .count           (count),
    .word_space      (word_space),
    .overflow        (overflow),
    .clear_overflow  (clear_overflow)
  );

  typedef struct {
    logic       rst;
    logic       push;
    logic [7:0] din;
    logic       pop;
    logic       clr;
    int         e_count;
    logic [7:0] e_out;
    logic       e_empty;
    logic       e_full;
    logic       e_ws;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic push, logic [7:0] din, logic p, int c,
                              logic [7:0] o, logic e);
    vec_t v;
    v.rst = rst; v.push = push; v.din = din; v.pop = p; v.clr = 1'b0;
    v.e_count = c; v.e_out = o; v.e_empty = e; v.e_full = 1'b0; v.e_ws = 1'b1;
    v.e_ovf = 1'b0;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1ns after the edge.
  task automatic step(input logic rst, input logic push, input logic [7:0] din,
                      input logic p, input logic clr);
    reset_n = ~rst; FIFO_push_data = push; FIFO_input_data = din;
    pop = p; clear_overflow = clr;
    @(posedge clk_pll);
    #1;
    reset_n = 1'b1; FIFO_push_data = 1'b0; pop = 1'b0; clear_overflow = 1'b0;
  endtask

  task automatic chk_state(input string name, input int c, input logic e, input logic f,
                           input logic ws, input logic ovf);
    chk({name, ".count"}, int'(count), c);
    chk({name, ".empty"}, int'(empty), int'(e));
    chk({name, ".full"}, int'(full), int'(f));
    chk({name, ".word_space"}, int'(word_space), int'(ws));
    chk({name, ".overflow"}, int'(overflow), int'(ovf));
  endtask

  logic [7:0] model_q[$];

  initial begin
    reset_n = 1'b0; FIFO_push_data = 1'b0; FIFO_input_data = 8'h00;
    pop = 1'b0; clear_overflow = 1'b0;

    // rst push din pop count out empty
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 1));
    vecs.push_back(mk(0, 1, 8'h11, 0, 1, 8'h11, 0));
    vecs.push_back(mk(0, 1, 8'h22, 0, 2, 8'h11, 0));
    vecs.push_back(mk(0, 1, 8'h33, 0, 3, 8'h11, 0));
    vecs.push_back(mk(0, 1, 8'h44, 0, 4, 8'h11, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 3, 8'h22, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 2, 8'h33, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 8'h44, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 1));  // pop while empty ignored
    vecs.push_back(mk(0, 1, 8'h77, 1, 1, 8'h77, 0));  // push+pop while empty
    vecs.push_back(mk(0, 1, 8'h88, 1, 1, 8'h88, 0));  // push+pop, count held
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 1));
    vecs.push_back(mk(0, 1, 8'h99, 0, 1, 8'h99, 0));
    vecs.push_back(mk(1, 1, 8'hEE, 1, 0, 8'h00, 1));  // reset wins over push/pop

    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      step(vecs[i].rst, vecs[i].push, vecs[i].din, vecs[i].pop, vecs[i].clr);
      chk_state(nm, vecs[i].e_count, vecs[i].e_empty, vecs[i].e_full, vecs[i].e_ws,
                vecs[i].e_ovf);
      chk({nm, ".out_data"}, int'(out_data), int'(vecs[i].e_out));
    end

    // Fill to full, then overflow and clear.
    for (int i = 0; i < 16; i++) step(0, 1, 8'(i), 0, 0);
    chk_state("fill16", 16, 0, 1, 0, 0);
    chk("fill16.out_data", int'(out_data), 'h00);
    step(0, 1, 8'hAA, 0, 0);
    chk_state("drop", 16, 0, 1, 0, 1);
    step(0, 0, 8'h00, 0, 1);
    chk("clear.overflow", int'(overflow), 0);
    step(0, 1, 8'hAB, 0, 1);
    chk("set_wins.overflow", int'(overflow), 1);
    step(0, 0, 8'h00, 0, 1);
    chk("clear2.overflow", int'(overflow), 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d.out_data", i), int'(out_data), i);
      step(0, 0, 8'h00, 1, 0);
    end
    chk_state("drained", 0, 1, 0, 1, 0);

    // word_space boundary at count 12/13.
    for (int i = 0; i < 12; i++) step(0, 1, 8'(8'h40 + i), 0, 0);
    chk_state("ws12", 12, 0, 0, 1, 0);
    step(0, 1, 8'h4C, 0, 0);
    chk_state("ws13", 13, 0, 0, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    chk_state("ws12b", 12, 0, 0, 1, 0);
    chk("ws12b.out_data", int'(out_data), 'h41);
    for (int i = 0; i < 12; i++) step(0, 0, 8'h00, 1, 0);
    chk_state("ws_drained", 0, 1, 0, 1, 0);

    // Full FIFO with simultaneous push+pop.
    for (int i = 0; i < 16; i++) step(0, 1, 8'(8'h80 + i), 0, 0);
    step(0, 1, 8'h5A, 1, 0);
    chk_state("full_pp", 16, 0, 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("full_pp_pop%0d.out_data", i), int'(out_data),
          (i < 15) ? 'h81 + i : 'h5A);
      step(0, 0, 8'h00, 1, 0);
    end
    chk_state("full_pp_done", 0, 1, 0, 1, 0);

    // 40 bytes streamed with concurrent push/pop; pointers wrap more than twice.
    model_q.delete();
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      logic       p;
      b = 8'(i * 7 + 3);
      p = (i >= 4);
      if (p) begin
        chk($sformatf("stream%0d.out_data", i), int'(out_data), int'(model_q[0]));
        void'(model_q.pop_front());
      end
      model_q.push_back(b);
      step(0, 1, b, p, 0);
    end
    chk("stream.count", int'(count), 4);
    chk("stream.head", int'(out_data), int'(model_q[0]));
    step(1, 1, 8'hF0, 1, 0);
    chk_state("mid_reset", 0, 1, 0, 1, 0);
    chk("mid_reset.out_data", int'(out_data), 'h00);
    step(0, 1, 8'hC3, 0, 0);
    chk_state("post_reset", 1, 0, 0, 1, 0);
    chk("post_reset.out_data", int'(out_data), 'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tx_byte_fifo.md
# tx_byte_fifo

Synchronous byte FIFO that sits directly downstream of the 32-bit-to-byte unpacker on the result path toward the USB transmit interface. It absorbs the unpacker's 4-beat push bursts, which have no backpressure, and presents bytes first-word-fall-through to the USB transmit side. It also reports whether a whole 32-bit result (4 bytes) can currently be accepted, so the result source can stall instead of overflowing.

## Interface
- DEPTH, 16, number of byte entries; power of two, ≥ 8
- AW, $clog2(DEPTH), pointer width
- clk_pll  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- FIFO_push_data  in  1  write strobe, one byte per cycle while high
- FIFO_input_data  in  8  byte written when FIFO_push_data=1
- pop  in  1  consumer accepts out_data this cycle
- out_data  out  8  head byte (FWFT); 8'h00 while empty
- empty  out  1  no entries stored
- full  out  1  count == DEPTH
- count  out  AW+1  entries stored, 0..DEPTH
- word_space  out  1  count ≤ DEPTH-4 (room for one full 32-bit result)
- overflow  out  1  sticky: a push was dropped
- clear_overflow  in  1  clears overflow

## Operation
- Storage: DEPTH×8 array, write pointer wr_ptr and read pointer rd_ptr (AW bits each), separate count register (AW+1 bits). Pointers wrap modulo DEPTH by natural overflow.
- Push accepted when FIFO_push_data=1 and (!full or pop accepted in the same cycle): mem[wr_ptr] ← FIFO_input_data, wr_ptr+1.
- Pop accepted when pop=1 and !empty: rd_ptr+1.
- Pop while empty: ignored, no state change, no error.
- Push while full without pop: byte dropped, pointers unchanged, overflow←1.
- Simultaneous push+pop, non-empty and non-full: both accepted, count unchanged.
- Simultaneous push+pop while full: both accepted, count stays DEPTH, full stays 1, overflow not set.
- Simultaneous push+pop while empty: push accepted, pop ignored, count→1.
- count update: +1 push only, −1 pop only, unchanged for both or neither.
- overflow: set on a dropped push, cleared by clear_overflow; set wins when both happen in the same cycle.
- Flags are derived combinationally from count: empty=(count==0), full=(count==DEPTH), word_space=(count≤DEPTH-4).
- out_data = empty ? 8'h00 : mem[rd_ptr]. The read is combinational from the registered rd_ptr.

## Timing
- Reset (reset_n=0 at an edge): wr_ptr=rd_ptr=0, count=0, overflow=0. Outputs after that edge: empty=1, full=0, word_space=1, out_data=8'h00. Memory contents are not reset.
- Reset mid-operation discards all stored bytes immediately. A push or pop in the reset cycle is ignored.
- Write-to-read latency: a byte pushed at edge N is visible on out_data, with empty=0, in the cycle after edge N.
- Pop at edge N: the next entry is on out_data in the cycle after edge N, or 8'h00 with empty=1 if the FIFO is now empty.
- All flags and count reflect state after the most recent edge; there is no extra pipeline stage.
- Sustained throughput: 1 push and 1 pop per cycle.
- Upstream contract: start a 4-byte burst only when word_space=1. With that rule, overflow never sets under 4-beat bursts.

## Structure
- Shared package (fpusb_pkg): BYTE_W=8, WORD_BYTES=4. word_space uses DEPTH-WORD_BYTES.
- One sub-module: tx_fifo_ram, a DEPTH×8 array with a synchronous write port and an asynchronous read port. Pointer, count and flag logic stays in tx_byte_fifo.

## Test plan
- Reset, then idle → empty=1, full=0, count=0, word_space=1, overflow=0, out_data=8'h00.
- Push 0x11,0x22,0x33,0x44 on consecutive cycles, then pop 4 times → out_data is 0x11,0x22,0x33,0x44 in order; empty=1 after the last pop; count ends at 0.
- Push 0x00..0x0F (DEPTH=16), then push 0xAA → full=1, count=16, overflow=1, byte 0xAA dropped. After one cycle of clear_overflow, overflow=0. Popping 16 times yields 0x00..0x0F.
- With count=12, push 1 more → word_space goes 1→0. Pop 1 → word_space=1.
- Full FIFO, push 0x5A and pop in the same cycle → count stays 16, overflow=0. 0x5A emerges last after 16 pops.
- Drive 40 bytes with concurrent push/pop so the pointers wrap twice → output order matches input; apply reset_n=0 mid-stream → next cycle count=0, empty=1.
